// File: rtl/shift_pkg.sv
// Shared constants for the sequential barrel shifter: op codes,
// FSM state encodings and default widths.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [1:0] OP_SLL     = 2'b00;
  localparam logic [1:0] OP_SRL     = 2'b01;
  localparam logic [1:0] OP_SRA     = 2'b10;
  localparam logic [1:0] OP_SRL_ALT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel stage: shifts by 2^k when enabled,
// otherwise passes the word through unchanged.
module shift_stage #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int KW     = 3
) (
  input  logic [DATA_W-1:0] work_i,
  input  logic [1:0]        op_i,
  input  logic [KW-1:0]     k_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] work_o
);
  import shift_pkg::*;

  logic [AMT_W-1:0] sh;

  assign sh = AMT_W'(1) << k_i;

  always_comb begin
    work_o = work_i;
    if (en_i) begin
      unique case (op_i)
        OP_SLL:  work_o = work_i << sh;
        OP_SRA:  work_o = $signed(work_i) >>> sh;
        default: work_o = work_i >> sh;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter, one barrel stage per cycle with start/busy/done.
// Optional SHIFT_SEQ_ZERO_BYPASS_EN completes zero-amount shifts in one cycle.
module shift_seq #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int AMT_W  = shift_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       amt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  import shift_pkg::*;

  localparam int KW = cnt_w(AMT_W);
  localparam logic [KW-1:0] K_LAST = KW'(AMT_W - 1);

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0]        op_q, op_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [DATA_W-1:0] stage_out;
  logic              unused_amt_hi;

  // Only the low AMT_W amount bits can ever matter.
  assign unused_amt_hi = ^amt[31:AMT_W];

  shift_stage #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W),
    .KW     (KW)
  ) u_stage (
    .work_i (work_q),
    .op_i   (op_q),
    .k_i    (k_q),
    .en_i   (amt_q[k_q]),
    .work_o (stage_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    res_d   = res_q;
    op_d    = op_q;
    amt_d   = amt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          work_d  = data_in;
          op_d    = op;
          amt_d   = amt[AMT_W-1:0];
          k_d     = '0;
          state_d = ST_RUN;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
          if (amt[AMT_W-1:0] == '0) begin
            res_d   = data_in;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        work_d = stage_out;
        if (k_q == K_LAST) begin
          res_d   = stage_out;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      work_q  <= '0;
      res_q   <= '0;
      op_q    <= OP_SLL;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      res_q   <= res_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = res_q;

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift unit downstream of the 5→32-bit shift-amount zero-extender.
- Consumes the extended shift amount and the rt operand for SLL/SRL/SRA and their variable forms.
- Applies one barrel stage per cycle: stage k shifts by 2^k when amount bit k is set.
- Start/busy/done handshake to the controller; the result is registered and held until the next completion.

Parameters:
- DATA_W, 32, operand/result width.
- AMT_W, 5, number of barrel stages and amount bits used. Must equal log2(DATA_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is not busy
- op  in  2  00=SLL, 01=SRL, 10=SRA, 11=SRL (alias)
- data_in  in  DATA_W  operand to shift
- amt  in  32  zero-extended shift amount; only amt[AMT_W-1:0] is used, bits above are ignored
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  last completed result

Behaviour:
- States:
  - IDLE: the only state out of reset.
  - RUN: counter k runs 0..AMT_W-1.
  - DONE: lasts exactly one cycle.
- Reset (synchronous, rst=1 at an edge) sets: state=IDLE, k=0, busy=0, done=0, result=0, work=0.
  - Reset also applies mid-RUN and in DONE; the in-flight operation is discarded and no done is issued.
- IDLE or DONE with start=1:
  - Latch data_in into work, op, and amt[AMT_W-1:0].
  - Set k=0 and go to RUN.
  - In DONE this gives back-to-back operation.
- IDLE or DONE with start=0: go to or stay in IDLE.
- RUN, each cycle:
  - If amt_l[k]=1, work <= work shifted by 2^k. SLL fills with 0. SRL and 11 fill with 0. SRA fills with work[DATA_W-1].
  - If amt_l[k]=0, work is unchanged.
  - When k=AMT_W-1: result <= stage output, go to DONE. Otherwise k++.
- start while in RUN is ignored; inputs are not re-sampled.
- Latency: start high in cycle c → busy=1 in cycles c+1..c+5 → done=1 and result valid in cycle c+6.
  - result holds until the next completion.
- done=1 only in DONE; busy=1 only in RUN; the two are never high together.
- Amount 0: all stages pass through; result=data_in at c+6 (base build).
- Shift by DATA_W-1 is the maximum. Amount bits ≥AMT_W never affect the result.
- result is never updated mid-operation; the intermediate value lives only in work.

Optional Feature:
- Macro: SHIFT_SEQ_ZERO_BYPASS_EN.
- Defined: start with amt[AMT_W-1:0]==0 goes IDLE/DONE → DONE directly, with result <= data_in. done is then high in cycle c+1 and busy never asserts. Nonzero amounts are unaffected.
- Undefined: all amounts take the full c+6 latency.

Decomposition:
- Package shift_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_SRL_ALT=2'b11
  - state encodings: ST_IDLE, ST_RUN, ST_DONE
  - default widths: DATA_W=32, AMT_W=5
- Sub-module shift_stage: purely combinational single barrel stage.
  - Inputs: work, op, stage index k, enable bit.
  - Output: work shifted by 2^k or passed through.
  - shift_seq instantiates one and muxes k into it.

Test Plan:
- SLL, data_in=0x00000001, amt=0x0000001F, start at c → done at c+6, result=0x80000000, busy high c+1..c+5.
- SRA, data_in=0x80000000, amt=4 → result=0xF8000000. SRL with same inputs → 0x08000000. Op 11 with same inputs → 0x08000000.
- SLL, data_in=0x0000000F, amt=0xFFFFFFE3 (upper bits ignored, shift 3) → result=0x00000078.
- start pulsed again at c+2 with different data → ignored; done once at c+6 with original result. start held in the DONE cycle → second done at c+12.
- rst asserted at c+3 mid-RUN → next cycle busy=0, done=0, result=0; no done pulse follows.
- amt=0, data_in=0xDEADBEEF:
  - base build: done at c+6, result=0xDEADBEEF
  - with SHIFT_SEQ_ZERO_BYPASS_EN: done at c+1, busy never high.
